// File: rtl/enoc_pkg.sv
// Shared ENoC router definitions: packet format, port indices and default router size.
package enoc_pkg;

    localparam int ENOC_N = 5;
    localparam int ENOC_M = 5;

    // Output-port indices of a mesh/torus router.
    localparam logic [2:0] LOCAL = 3'd0;
    localparam logic [2:0] NORTH = 3'd1;
    localparam logic [2:0] EAST  = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] WEST  = 3'd4;

    typedef struct packed {
        logic [7:0]  dest;
        logic [7:0]  src;
        logic [15:0] payload;
    } packet_t;

endpackage

// File: rtl/enoc_rr_arbiter.sv
// Round-robin arbiter for one output port: one-hot grant to the first requester
// at or after the pointer; the pointer moves just past the winner on each grant.
module enoc_rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] ptr_next_s;
    logic [N-1:0]  grant_s;
    logic          found_s;
    logic [IW:0]   idx_s;

    // Search upward from the pointer (mod N) for the first active requester.
    always_comb begin
        grant_s    = '0;
        found_s    = 1'b0;
        ptr_next_s = ptr_r;
        idx_s      = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx_s = {1'b0, ptr_r} + (IW+1)'(k);
                if (idx_s >= (IW+1)'(N)) begin
                    idx_s = idx_s - (IW+1)'(N);
                end else begin
                    idx_s = idx_s;
                end
                if (!found_s && req[idx_s[IW-1:0]]) begin
                    grant_s[idx_s[IW-1:0]] = 1'b1;
                    found_s                = 1'b1;
                    if (idx_s == (IW+1)'(N - 1)) begin
                        ptr_next_s = '0;
                    end else begin
                        ptr_next_s = IW'(idx_s + (IW+1)'(1));
                    end
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            grant_s = '0;
        end
    end

    // Pointer advances only when a grant is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/enoc_switch_allocator.sv
// Switch allocator and output stage of an ENoC router: per-output round-robin
// arbitration, same-cycle pop strobes, crossbar into one-deep output registers.
module enoc_switch_allocator
    import enoc_pkg::*;
#(
    parameter  int N  = ENOC_N,
    parameter  int M  = ENOC_M,
    localparam int PW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          i_req_val,
    input  logic [N-1:0][PW-1:0]  i_req_port,
    input  packet_t [N-1:0]       i_data,
    output logic [N-1:0]          o_grant,
    output packet_t [M-1:0]       o_data,
    output logic [M-1:0]          o_data_val,
    input  logic [M-1:0]          i_en,
    output logic                  o_err
);

    logic [M-1:0][N-1:0] req_s;
    logic [M-1:0][N-1:0] gnt_s;
    logic [N-1:0]        bad_s;
    logic [M-1:0]        free_s;
    logic [M-1:0]        arb_en_s;
    logic [M-1:0]        won_s;
    logic [N-1:0]        grant_s;
    packet_t [M-1:0]     xbar_s;
    packet_t [M-1:0]     data_r;
    logic [M-1:0]        val_r;
    logic                err_r;

    // Request matrix: each valid input asks for exactly one port; out-of-range ports are flagged.
    always_comb begin
        req_s = '0;
        bad_s = '0;
        for (int i = 0; i < N; i++) begin
            if (i_req_val[i]) begin
                if ({1'b0, i_req_port[i]} >= (PW+1)'(M)) begin
                    bad_s[i] = 1'b1;
                end else begin
                    for (int j = 0; j < M; j++) begin
                        if (i_req_port[i] == PW'(j)) begin
                            req_s[j][i] = 1'b1;
                        end else begin
                            req_s[j][i] = 1'b0;
                        end
                    end
                end
            end else begin
                bad_s[i] = 1'b0;
            end
        end
    end

    // An output can take a new packet when empty or being drained this cycle.
    assign free_s   = ~val_r | i_en;
    assign arb_en_s = free_s & {M{~reset}};

    genvar gj;
    for (gj = 0; gj < M; gj++) begin : g_arb
        enoc_rr_arbiter #(.N(N)) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req_s[gj]),
            .en    (arb_en_s[gj]),
            .grant (gnt_s[gj])
        );
    end

    // Crossbar select and pop strobes from the one-hot grants.
    always_comb begin
        xbar_s  = '0;
        won_s   = '0;
        grant_s = '0;
        for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_s[j][i]) begin
                    xbar_s[j]  = i_data[i];
                    won_s[j]   = 1'b1;
                    grant_s[i] = 1'b1;
                end else begin
                    grant_s[i] = grant_s[i];
                end
            end
        end
    end

    // Output registers: refill on a grant, drain on accept, otherwise hold; sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= '0;
            val_r  <= '0;
            err_r  <= 1'b0;
        end else begin
            for (int j = 0; j < M; j++) begin
                if (won_s[j]) begin
                    data_r[j] <= xbar_s[j];
                    val_r[j]  <= 1'b1;
                end else if (i_en[j]) begin
                    val_r[j]  <= 1'b0;
                end else begin
                    val_r[j]  <= val_r[j];
                end
            end
            err_r <= err_r | (|bad_s);
        end
    end

    assign o_grant    = grant_s;
    assign o_data     = data_r;
    assign o_data_val = val_r;
    assign o_err      = err_r;

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed scoreboard bench for enoc_switch_allocator.
module tb_enoc_switch_allocator;
    import enoc_pkg::*;

    localparam int N  = 5;
    localparam int M  = 5;
    localparam int PW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         i_req_val;
    logic [N-1:0][PW-1:0] i_req_port;
    packet_t [N-1:0]      i_data;
    logic [N-1:0]         o_grant;
    packet_t [M-1:0]      o_data;
    logic [M-1:0]         o_data_val;
    logic [M-1:0]         i_en;
    logic                 o_err;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    enoc_switch_allocator dut (
        .clk        (clk),
        .reset      (reset),
        .i_req_val  (i_req_val),
        .i_req_port (i_req_port),
        .i_data     (i_data),
        .o_grant    (o_grant),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .i_en       (i_en),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pkt(input int i, input logic [7:0] tag);
        pkt = {tag, 8'(i), 16'hA000 + 16'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic [PW-1:0] port, input logic [31:0] d);
        i_req_val[i]  = 1'b1;
        i_req_port[i] = port;
        i_data[i]     = packet_t'(d);
    endtask

    task automatic clr_reqs();
        i_req_val  = '0;
        i_req_port = '0;
        i_data     = '0;
    endtask

    task automatic push(input int port, input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_val", 64'(o_data_val[e.port]), 64'd1);
            chk("out_data", 64'(o_data[e.port]), 64'(e.data));
        end
    endtask

    initial begin
        int order[6];
        int cnt[N];
        order = '{0, 1, 4, 0, 1, 4};
        cnt   = '{default: 0};

        // 1: reset with every input requesting
        reset     = 1'b1;
        i_en      = '1;
        i_req_val = '1;
        i_req_port = '0;
        i_data    = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_grant", 64'(o_grant), 64'd0);
            tick();
            chk("rst_val", 64'(o_data_val), 64'd0);
            chk("rst_err", 64'(o_err), 64'd0);
            chk("rst_data", 64'(o_data), 64'd0);
        end
        reset = 1'b0;
        clr_reqs();
        tick();

        // 2: single path, input 2 -> SOUTH
        req(2, SOUTH, pkt(2, 8'hAA));
        #1;
        chk("single_grant", 64'(o_grant), 64'h04);
        push(3, pkt(2, 8'hAA));
        tick();
        clr_reqs();
        check_out();
        chk("single_valmask", 64'(o_data_val), 64'h08);
        tick();

        // 3: fairness on EAST among inputs 0,1,4
        req(0, EAST, pkt(0, 8'hC0));
        req(1, EAST, pkt(1, 8'hC1));
        req(4, EAST, pkt(4, 8'hC4));
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("fair_grant", 64'(o_grant), 64'(5'b1 << order[c]));
            for (int i = 0; i < N; i++) begin
                if (o_grant[i]) cnt[i]++;
            end
            push(2, pkt(order[c], 8'hC0 + 8'(order[c])));
            tick();
            check_out();
        end
        chk("fair_cnt0", 64'(cnt[0]), 64'd2);
        chk("fair_cnt1", 64'(cnt[1]), 64'd2);
        chk("fair_cnt4", 64'(cnt[4]), 64'd2);
        clr_reqs();
        tick();

        // 4: backpressure on NORTH
        i_en[1] = 1'b0;
        req(0, NORTH, pkt(0, 8'hB0));
        req(3, NORTH, pkt(3, 8'hB3));
        #1;
        chk("bp_first", 64'(o_grant), 64'h01);
        push(1, pkt(0, 8'hB0));
        tick();
        check_out();
        i_req_val[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_nogrant", 64'(o_grant), 64'd0);
            tick();
            chk("bp_hold_val", 64'(o_data_val[1]), 64'd1);
            chk("bp_hold_data", 64'(o_data[1]), 64'(pkt(0, 8'hB0)));
        end
        i_en[1] = 1'b1;
        #1;
        chk("bp_release", 64'(o_grant), 64'h08);
        push(1, pkt(3, 8'hB3));
        tick();
        check_out();
        clr_reqs();
        tick();

        // 5: all five inputs to distinct ports in one cycle
        for (int i = 0; i < N; i++) begin
            req(i, PW'(4 - i), pkt(i, 8'hD0));
            push(4 - i, pkt(i, 8'hD0));
        end
        #1;
        chk("par_grant", 64'(o_grant), 64'h1F);
        tick();
        check_out();
        chk("par_valmask", 64'(o_data_val), 64'h1F);
        clr_reqs();
        tick();

        // 6: invalid port alongside LOCAL traffic, then reset mid-run
        req(3, 3'd6, pkt(3, 8'hEE));
        req(0, LOCAL, pkt(0, 8'hE0));
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("err_grant", 64'(o_grant), 64'h01);
            push(0, pkt(0, 8'hE0));
            tick();
            check_out();
            chk("err_flag", 64'(o_err), 64'd1);
        end
        req(2, LOCAL, pkt(2, 8'hE2));
        reset = 1'b1;
        #1;
        chk("midrst_grant", 64'(o_grant), 64'd0);
        tick();
        chk("midrst_err", 64'(o_err), 64'd0);
        chk("midrst_val", 64'(o_data_val), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_grant", 64'(o_grant), 64'h01);
        push(0, pkt(0, 8'hE0));
        tick();
        check_out();
        chk("post_rst_err", 64'(o_err), 64'd1);
        clr_reqs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
